// File: rtl/sm_pipe_ctrl_slot.sv
// One pipeline stage of the valid/stall/flush sequencer: owns the stage's
// valid flop and computes whether its content is live and moves this cycle.
module sm_pipe_ctrl_slot (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic hold,
  input  logic dn_free,
  input  logic up_move,
  output logic v,
  output logic lv,
  output logic mv
);

  logic v_next;

  always_comb begin
    lv     = v & ~flush;
    mv     = lv & ~hold & dn_free;
    // A killed stage also drops whatever enters it this cycle.
    v_next = ~flush & (up_move | (v & ~mv));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v <= 1'b0;
    end else begin
      v <= v_next;
    end
  end

endmodule

// File: rtl/sm_pipe_ctrl.sv
// Valid/stall/flush sequencer for a linear chain of write-enabled pipeline
// registers, with occupancy and saturating stall-cycle counters.
module sm_pipe_ctrl #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [STAGES-1:0]                hold,
  input  logic [STAGES-1:0]                flush,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [STAGES-1:0]                stage_we,
  output logic [STAGES-1:0]                stage_valid,
  output logic [$clog2(STAGES+1)-1:0]      occupancy,
  output logic [CNT_W-1:0]                 stall_cnt
);

  localparam int unsigned       OCC_W   = $clog2(STAGES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic              ready_raw;
  logic              accept;
  logic [STAGES-1:0] v_vec;
  logic [STAGES-1:0] we_vec;

  // Per-stage signals live in their own generate scope so the ready chain
  // is a set of distinct nets rather than one self-referencing vector.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic v;
    logic lv;
    logic mv;
    logic dn_free;
    logic up_move;

    if (i == STAGES - 1) begin : g_last
      assign dn_free = out_ready;
    end else begin : g_mid
      assign dn_free = ~g_stage[i+1].lv | g_stage[i+1].mv;
    end

    if (i == 0) begin : g_first
      assign up_move = accept;
    end else begin : g_rest
      assign up_move = g_stage[i-1].mv;
    end

    sm_pipe_ctrl_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush[i]),
      .hold    (hold[i]),
      .dn_free (dn_free),
      .up_move (up_move),
      .v       (v),
      .lv      (lv),
      .mv      (mv)
    );

    assign v_vec[i]  = v;
    assign we_vec[i] = up_move;
  end

  assign ready_raw   = ~g_stage[0].lv | g_stage[0].mv;
  assign in_ready    = rst & ready_raw;
  assign accept      = in_valid & in_ready;
  assign out_valid   = rst & g_stage[STAGES-1].lv & ~hold[STAGES-1];
  assign stage_we    = we_vec & {STAGES{rst}};
  assign stage_valid = v_vec;

  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(v_vec[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !ready_raw && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
